// File: rtl/window_spill_fill.sv
// window_spill_fill: moves one 16-word register window (locals + ins)
// between the windowed register file and a 64-byte memory save area.
// A spill reads each register and writes it to memory; a fill reads
// memory and writes each register back. Words go in ascending index order.
module window_spill_fill #(
    parameter int unsigned NWINDOWS = 8,
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned DATA_W   = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start_spill,
    input  logic              start_fill,
    input  logic [4:0]        win,
    input  logic [ADDR_W-1:0] sp,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              rf_rd_en,
    output logic              rf_wr_en,
    output logic [4:0]        rf_win,
    output logic [3:0]        rf_idx,
    output logic [DATA_W-1:0] rf_wr_data,
    input  logic [DATA_W-1:0] rf_rd_data,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [2:0] {
        IDLE,
        SP_RD,
        SP_CAP,
        SP_MEM,
        FL_REQ,
        FL_WAIT,
        FL_WR,
        DONE
    } state_t;

    state_t            state_q, state_d;
    logic [3:0]        idx_q;
    logic [4:0]        win_q;
    logic [ADDR_W-1:0] sp_q;
    logic              err_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;

    logic start_any;
    logic start_ok;
    logic last_word;

    // A start is good only if exactly one kind is requested, the save area
    // is doubleword aligned and the window exists.
    assign start_any = start_spill | start_fill;
    assign start_ok  = (start_spill ^ start_fill) && (sp[2:0] == 3'b000) &&
                       (32'(win) < NWINDOWS);
    // Completion is decided by the index value, never by counter wrap.
    assign last_word = (idx_q == 4'd15);

    assign rf_win     = win_q;
    assign rf_idx     = idx_q;
    assign rf_wr_data = rdata_q;
    assign mem_wdata  = wdata_q;
    // Save-area slot address; wraps modulo 2^ADDR_W by construction.
    assign mem_addr   = sp_q + {{(ADDR_W-6){1'b0}}, idx_q, 2'b00};

    // State register with synchronous abort on reset.
    always_ff @(posedge clk) begin
        // NOTE: clocked blocks use non-blocking (<=) so every register sees
        // pre-edge values; blocking here makes results depend on block order.
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode and per-state strobes.
    always_comb begin
        // NOTE: every signal written here gets a default first; any path that
        // left one unassigned would infer a latch.
        state_d  = state_q;
        busy     = 1'b0;
        done     = 1'b0;
        err      = 1'b0;
        rf_rd_en = 1'b0;
        rf_wr_en = 1'b0;
        mem_req  = 1'b0;
        mem_we   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_any) begin
                    if (!start_ok)        state_d = DONE;
                    else if (start_spill) state_d = SP_RD;
                    else                  state_d = FL_REQ;
                end
            end
            SP_RD: begin
                busy     = 1'b1;
                rf_rd_en = 1'b1;
                state_d  = SP_CAP;
            end
            SP_CAP: begin
                busy    = 1'b1;
                state_d = SP_MEM;
            end
            SP_MEM: begin
                busy    = 1'b1;
                mem_req = 1'b1;
                mem_we  = 1'b1;
                if (mem_ready) state_d = last_word ? DONE : SP_RD;
            end
            FL_REQ: begin
                busy    = 1'b1;
                mem_req = 1'b1;
                if (mem_ready) state_d = FL_WAIT;
            end
            FL_WAIT: begin
                busy = 1'b1;
                if (mem_rvalid) state_d = FL_WR;
            end
            FL_WR: begin
                busy     = 1'b1;
                rf_wr_en = 1'b1;
                state_d  = last_word ? DONE : FL_REQ;
            end
            DONE: begin
                // A rejected start never looks busy.
                busy    = !err_q;
                done    = 1'b1;
                err     = err_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Operand latches, word index and the two data capture registers.
    always_ff @(posedge clk) begin
        // NOTE: datapath registers are reset as well, because they drive
        // output ports that must read zero after reset.
        if (!reset) begin
            idx_q   <= '0;
            win_q   <= '0;
            sp_q    <= '0;
            err_q   <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_any) begin
                        err_q <= !start_ok;
                        if (start_ok) begin
                            win_q <= win;
                            sp_q  <= sp;
                            idx_q <= 4'd0;
                        end
                    end
                end
                SP_CAP:  wdata_q <= rf_rd_data;
                SP_MEM:  if (mem_ready && !last_word) idx_q <= idx_q + 4'd1;
                FL_WAIT: if (mem_rvalid) rdata_q <= mem_rdata;
                FL_WR:   if (!last_word) idx_q <= idx_q + 4'd1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_window_spill_fill.sv
// Bench for window_spill_fill: a register-file / memory environment answers
// the DUT on falling edges, and each operation is compared with the list of
// accesses the transfer rules predict (ascending slots sp+4k).
module tb_window_spill_fill;

    localparam int NW = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start_spill = 1'b0;
    logic        start_fill = 1'b0;
    logic [4:0]  win = '0;
    logic [31:0] sp = '0;
    logic        busy, done, err, rf_rd_en, rf_wr_en, mem_req, mem_we;
    logic [4:0]  rf_win;
    logic [3:0]  rf_idx;
    logic [31:0] rf_wr_data, mem_addr, mem_wdata;
    logic [31:0] rf_rd_data = '0;
    logic        mem_ready = 1'b0;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = '0;

    window_spill_fill #(.NWINDOWS(NW), .ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .reset(reset),
        .start_spill(start_spill), .start_fill(start_fill),
        .win(win), .sp(sp),
        .busy(busy), .done(done), .err(err),
        .rf_rd_en(rf_rd_en), .rf_wr_en(rf_wr_en),
        .rf_win(rf_win), .rf_idx(rf_idx),
        .rf_wr_data(rf_wr_data), .rf_rd_data(rf_rd_data),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ready(mem_ready),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Environment state: register file, sparse memory, access logs.
    logic [31:0] rf_m [0:31][0:15];
    logic [31:0] mem_m [logic [31:0]];
    logic [63:0] mw_log [$];
    logic [31:0] mr_log [$];
    logic [63:0] rw_log [$];
    int rd_cnt = 0, wr_cnt = 0, req_cnt = 0, stall_total = 0, stab_err = 0;
    int req_num = 0, stall_left = 0, stall_mode = 0;
    bit noise = 0, block_en = 0, inject_rv = 0;
    bit rd_pend = 0, rv_pend = 0, req_fresh = 1, stalled_prev = 0;
    logic [4:0]  rd_win = '0;
    logic [3:0]  rd_idx = '0;
    logic [31:0] rv_addr = '0, block_addr = '0;
    logic [64:0] st_fields = '0;

    typedef struct {
        bit          spill;
        bit          both;
        logic [4:0]  w;
        logic [31:0] s;
        int          stall;
        bit          exp_err;
        int          exp_done;
        string       name;
    } vec_t;
    vec_t tbl [$];

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        return mem_m.exists(a) ? mem_m[a] : ~a;
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic add_vec(input bit spl, input bit both, input logic [4:0] w,
                           input logic [31:0] s, input int stall, input bit e,
                           input int d, input string name);
        vec_t v;
        v.spill = spl; v.both = both; v.w = w; v.s = s; v.stall = stall;
        v.exp_err = e; v.exp_done = d; v.name = name;
        tbl.push_back(v);
    endtask

    task automatic clear_env();
        mw_log.delete(); mr_log.delete(); rw_log.delete();
        rd_cnt = 0; wr_cnt = 0; req_cnt = 0; stall_total = 0; stab_err = 0;
        req_num = 0; stall_left = 0; rv_pend = 0; req_fresh = 1; stalled_prev = 0;
    endtask

    // Register file and memory responder, acting mid-cycle.
    always @(negedge clk) begin
        rf_rd_data = rd_pend ? rf_m[rd_win][rd_idx] : 32'hDEAD_BEEF;
        rd_pend = rf_rd_en; rd_win = rf_win; rd_idx = rf_idx;
        if (rf_rd_en) rd_cnt++;
        if (rf_wr_en) begin
            wr_cnt++;
            rw_log.push_back({23'b0, rf_win, rf_idx, rf_wr_data});
            rf_m[rf_win][rf_idx] = rf_wr_data;
        end
        mem_rvalid = inject_rv;
        mem_rdata  = $urandom;
        if (rv_pend) begin
            mem_rvalid = !(block_en && rv_addr == block_addr);
            mem_rdata  = mem_rd(rv_addr);
            rv_pend    = 0;
        end else if (noise && (mem_req || rf_rd_en || rf_wr_en || !busy)) begin
            mem_rvalid = 1'($urandom_range(0, 1));
        end
        mem_ready = 1'b0;
        if (mem_req) begin
            req_cnt++;
            if (stalled_prev && st_fields !== {mem_addr, mem_we, mem_wdata}) stab_err++;
            if (req_fresh) begin
                if (stall_mode == 1)      stall_left = (req_num % 4 == 0) ? 2 : 0;
                else if (stall_mode == 2) stall_left = $urandom_range(0, 2);
                else                      stall_left = 0;
                req_fresh = 0;
                req_num++;
            end
            if (stall_left > 0) begin
                stall_left--;
                stall_total++;
                stalled_prev = 1;
                st_fields = {mem_addr, mem_we, mem_wdata};
            end else begin
                mem_ready = 1'b1;
                req_fresh = 1;
                stalled_prev = 0;
                if (mem_we) begin
                    mem_m[mem_addr] = mem_wdata;
                    mw_log.push_back({mem_addr, mem_wdata});
                end else begin
                    mr_log.push_back(mem_addr);
                    rv_pend = 1;
                    rv_addr = mem_addr;
                end
            end
        end else begin
            stalled_prev = 0;
            if (noise) mem_ready = 1'($urandom_range(0, 1));
        end
    end

    // One operation from start pulse to the idle cycle after done.
    task automatic run_op(input bit do_spill, input bit do_both, input logic [4:0] w,
                          input logic [31:0] s, input int intrude_at, input bit exp_err,
                          input int exp_done_in, input string tag);
        logic [63:0] exp_q [$];
        logic [31:0] exp_a [$];
        logic [31:0] a;
        int c, done_cyc, busy_hi, err_cnt, mism, amism, exp_done;
        for (int k = 0; k < 16; k++) begin
            a = s + 32'(4 * k);
            exp_a.push_back(a);
            if (do_spill) exp_q.push_back({a, rf_m[w][k]});
            else          exp_q.push_back({23'b0, w, 4'(k), mem_rd(a)});
        end
        clear_env();
        start_spill = do_spill | do_both;
        start_fill  = !do_spill | do_both;
        win = w;
        sp  = s;
        @(negedge clk);
        start_spill = 1'b0;
        start_fill  = 1'b0;
        win = 5'($urandom);
        sp  = $urandom;
        c = 1; done_cyc = -1; busy_hi = 0; err_cnt = 0;
        while (c <= 200) begin
            if (busy) busy_hi++;
            if (err) err_cnt++;
            if (done) begin
                done_cyc = c;
                break;
            end
            start_fill = (c == intrude_at);
            if (c == intrude_at) begin
                win = 5'd1;
                sp  = 32'h8;
            end
            @(negedge clk);
            c++;
        end
        start_fill = 1'b0;
        exp_done = (exp_done_in > 0) ? exp_done_in : (exp_err ? 1 : 49 + stall_total);
        check({tag, " done_cycle"}, 64'(done_cyc), 64'(exp_done));
        check({tag, " err_pulses"}, 64'(err_cnt), 64'(exp_err ? 1 : 0));
        check({tag, " busy_cycles"}, 64'(busy_hi), 64'(exp_err ? 0 : exp_done));
        if (exp_err) begin
            check({tag, " activity"}, 64'(rd_cnt + wr_cnt + req_cnt), 64'(0));
        end else begin
            check({tag, " stall_stable"}, 64'(stab_err), 64'(0));
            mism = 0;
            amism = 0;
            if (do_spill) begin
                check({tag, " mem_wr_count"}, 64'(mw_log.size()), 64'(16));
                check({tag, " rf_rd_count"}, 64'(rd_cnt), 64'(16));
                for (int k = 0; k < 16 && k < mw_log.size(); k++)
                    if (mw_log[k] !== exp_q[k]) mism++;
                check({tag, " mem_wr_bad"}, 64'(mism), 64'(0));
                check({tag, " rf_wr_count"}, 64'(wr_cnt), 64'(0));
            end else begin
                check({tag, " rf_wr_count"}, 64'(rw_log.size()), 64'(16));
                for (int k = 0; k < 16 && k < rw_log.size(); k++)
                    if (rw_log[k] !== exp_q[k]) mism++;
                for (int k = 0; k < 16 && k < mr_log.size(); k++)
                    if (mr_log[k] !== exp_a[k]) amism++;
                check({tag, " rf_wr_bad"}, 64'(mism), 64'(0));
                check({tag, " mem_rd_addr_bad"}, 64'(amism + 16 - mr_log.size()), 64'(0));
                check({tag, " rf_rd_count"}, 64'(rd_cnt), 64'(0));
            end
        end
        @(negedge clk);
        check({tag, " idle_after"}, 64'({busy, done, err}), 64'(0));
    endtask

    initial begin
        int found, late_bad, kind;
        bit sp_op, e;
        logic [4:0] w;
        logic [31:0] s;

        for (int i = 0; i < 32; i++)
            for (int k = 0; k < 16; k++) rf_m[i][k] = $urandom;
        for (int k = 0; k < 16; k++) begin
            rf_m[3][k] = 32'hA0 + 32'(k);
            mem_m[32'h2000 + 32'(4 * k)] = 32'h5000 + 32'(k);
        end

        repeat (3) @(negedge clk);
        check("reset_ctrl", 64'({busy, done, err, rf_rd_en, rf_wr_en, mem_req, mem_we}), 64'(0));
        check("reset_fields", 64'(|{rf_win, rf_idx, rf_wr_data, mem_addr, mem_wdata}), 64'(0));
        reset = 1'b1;
        @(negedge clk);

        add_vec(1, 0, 5'd3, 32'h0000_1000, 0, 0, 49, "spill_w3");
        add_vec(0, 0, 5'd5, 32'h0000_2000, 0, 0, 49, "fill_w5");
        add_vec(1, 0, 5'd3, 32'h0000_1000, 1, 0, 57, "spill_backpressure");
        add_vec(1, 0, 5'd3, 32'h0000_1004, 0, 1, 1, "err_misaligned");
        add_vec(1, 1, 5'd2, 32'h0000_3000, 0, 1, 1, "err_both_starts");
        add_vec(1, 0, 5'd9, 32'h0000_3000, 0, 1, 1, "err_win9");
        add_vec(0, 0, 5'd7, 32'hFFFF_FFE0, 0, 0, 49, "fill_w7_wrap");
        add_vec(1, 0, 5'd8, 32'h0000_3000, 0, 1, 1, "err_win8");
        add_vec(0, 0, 5'd1, 32'h0000_3002, 0, 1, 1, "err_fill_misaligned");
        add_vec(1, 0, 5'd0, 32'hFFFF_FFE0, 0, 0, 49, "spill_wrap");
        foreach (tbl[i]) begin
            stall_mode = tbl[i].stall;
            noise = 0;
            run_op(tbl[i].spill, tbl[i].both, tbl[i].w, tbl[i].s, 0,
                   tbl[i].exp_err, tbl[i].exp_done, tbl[i].name);
        end

        // A fill start arriving mid-spill must be ignored.
        stall_mode = 0;
        run_op(1, 0, 5'd2, 32'h0000_4000, 10, 0, 49, "start_while_busy");

        // Reset in the middle of a fill while word 7's read is outstanding.
        clear_env();
        block_en = 1;
        block_addr = 32'h0000_6000 + 32'd28;
        start_fill = 1'b1;
        win = 5'd4;
        sp = 32'h0000_6000;
        @(negedge clk);
        start_fill = 1'b0;
        found = 0;
        for (int c = 0; c < 100; c++) begin
            if (busy && !mem_req && !rf_wr_en && rf_idx == 4'd7) begin
                found = 1;
                break;
            end
            @(negedge clk);
        end
        check("reset_mid_fill reached_idx7_wait", 64'(found), 64'(1));
        check("reset_mid_fill writes_before", 64'(rw_log.size()), 64'(7));
        reset = 1'b0;
        #1 inject_rv = 1;
        @(negedge clk);
        reset = 1'b1;
        check("reset_abort_ctrl", 64'({busy, done, err, rf_rd_en, rf_wr_en, mem_req, mem_we}), 64'(0));
        check("reset_abort_fields", 64'(|{rf_win, rf_idx, rf_wr_data, mem_addr, mem_wdata}), 64'(0));
        #1 inject_rv = 0;
        late_bad = 0;
        repeat (4) begin
            @(negedge clk);
            if (busy | done | err | rf_wr_en | rf_rd_en | mem_req) late_bad++;
        end
        check("late_rvalid_ignored", 64'(late_bad), 64'(0));
        block_en = 0;
        run_op(1, 0, 5'd6, 32'h0000_9000, 0, 0, 49, "spill_after_reset");

        // Randomised operations with random stalls and stray handshakes.
        stall_mode = 2;
        noise = 1;
        for (int i = 0; i < 24; i++) begin
            kind = $urandom_range(0, 9);
            sp_op = 1'($urandom_range(0, 1));
            w = (kind == 1) ? 5'($urandom_range(8, 31)) : 5'($urandom_range(0, 7));
            s = $urandom;
            if (kind == 2) s[2:0] = 3'($urandom_range(1, 7));
            else           s[2:0] = 3'b000;
            if (kind == 3) s = 32'hFFFF_FFE8;
            e = (kind == 0) || (int'(w) >= NW) || (s[2:0] != 3'b000);
            run_op(sp_op, kind == 0, w, s, 0, e, 0, $sformatf("rand%0d", i));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/window_spill_fill.md
# window_spill_fill

Hardware engine that moves one SPARC register window between the register file and memory. A spill copies the window's 16 locals/ins to a 64-byte save area. A fill loads those 16 words back into the register file. It sits between the window-overflow/underflow trap logic and the data-memory port, and acts as the reader/writer counterpart of the windowed register file.

## Interface
Parameters:
- NWINDOWS, 8: number of implemented register windows; `win` must be < NWINDOWS.
- ADDR_W, 32: memory address width.
- DATA_W, 32: register/memory word width.

Ports:
- clk  in  1  single clock; all state updates on posedge.
- reset  in  1  synchronous, active-low; sampled on posedge clk.
- start_spill  in  1  one-cycle pulse; begin spill of window `win` to `sp`.
- start_fill  in  1  one-cycle pulse; begin fill of window `win` from `sp`.
- win  in  5  target window; latched at accepted start.
- sp  in  ADDR_W  save-area base; latched at accepted start.
- busy  out  1  high from the cycle after an accepted start through the DONE cycle.
- done  out  1  one-cycle pulse on completion or on error.
- err  out  1  one-cycle pulse, coincident with done, on rejected start.
- rf_rd_en  out  1  register read strobe; data returns next cycle.
- rf_wr_en  out  1  register write strobe.
- rf_win  out  5  latched window for rf accesses.
- rf_idx  out  4  window-relative index: 0–7 = locals r16–r23, 8–15 = ins r24–r31.
- rf_wr_data  out  DATA_W  write data.
- rf_rd_data  in  DATA_W  read data, valid the cycle after rf_rd_en.
- mem_req  out  1  memory request; held until mem_ready.
- mem_we  out  1  1 = write, 0 = read; stable while mem_req.
- mem_addr  out  ADDR_W  sp + 4*idx.
- mem_wdata  out  DATA_W  write data.
- mem_ready  in  1  request accepted this cycle.
- mem_rvalid  in  1  read data valid; at most one read outstanding.
- mem_rdata  in  DATA_W  read data.

## Operation
- States: IDLE, SP_RD, SP_CAP, SP_MEM, FL_REQ, FL_WAIT, FL_WR, DONE.
- IDLE acceptance:
  - Exactly one start, sp[2:0]==0, and win<NWINDOWS: latch win and sp, set idx=0, go to SP_RD (spill) or FL_REQ (fill).
  - Both starts high, misaligned sp, or win≥NWINDOWS: go to DONE with err; no rf or mem activity.
- Starts while not IDLE are ignored (no err).
- Spill, per idx:
  - SP_RD: rf_rd_en=1 for one cycle.
  - SP_CAP: capture rf_rd_data into mem_wdata.
  - SP_MEM: mem_req=1, mem_we=1, held until mem_ready.
  - Then idx+1 → SP_RD, or after idx 15 → DONE.
- Fill, per idx:
  - FL_REQ: mem_req=1, mem_we=0, held until mem_ready.
  - FL_WAIT: wait for mem_rvalid, then capture mem_rdata into rf_wr_data.
  - FL_WR: rf_wr_en=1 for one cycle.
  - Then idx+1 → FL_REQ, or after idx 15 → DONE.
- DONE: done=1 for one cycle, then IDLE.
- Address arithmetic: mem_addr = sp + {idx,2'b00}, modulo 2^ADDR_W; wrap-around is permitted and not flagged.
- idx is a 4-bit counter; completion is detected at idx==15, never by overflow.
- Accesses go strictly in ascending idx order; each word is touched exactly once.

## Timing
- Reset (reset==0 at posedge): state=IDLE, idx=0. busy, done, err, rf_rd_en, rf_wr_en, mem_req, mem_we = 0. rf_win, rf_idx, rf_wr_data, mem_addr, mem_wdata = 0.
- Reset mid-operation aborts immediately:
  - An in-flight memory request is dropped and no done is issued.
  - A mem_rvalid arriving after reset is ignored.
- Start acceptance: start sampled at posedge N. busy=1 and the first strobe (rf_rd_en or mem_req) appear at N+1.
- Spill with mem_ready tied high: 3 cycles per word, 48 cycles, then a done pulse at cycle 49 after acceptance.
- Fill with mem_ready high and mem_rvalid the cycle after acceptance: 3 cycles per word, 48 cycles, done at cycle 49.
- Memory backpressure: each cycle of mem_ready=0 adds exactly one cycle; mem_addr, mem_we and mem_wdata stay stable during the wait.
- mem_rvalid in FL_REQ or SP_* is ignored. mem_ready outside the request states is ignored.
- Error path: done=err=1 at N+1, busy=0 throughout.

## Test plan
- Spill: win=3, sp=0x1000, rf word k=0xA0+k, mem_ready=1 → writes of 0xA0..0xAF to 0x1000..0x103C in order; done at cycle 49; busy low after.
- Fill: win=5, sp=0x2000, memory word k=0x5000+k, rvalid one cycle after ready → rf_wr_en at idx 0..15 with data 0x5000..0x500F, rf_win=5; done at cycle 49.
- Backpressure: spill with mem_ready low for 2 cycles on every 4th word → 8 extra cycles (done at cycle 57); request fields stable while stalled.
- Errors: sp=0x1004 → done+err at N+1, no strobes. Both starts high → err. win=9 with NWINDOWS=8 → err. start_fill during a busy spill → ignored, spill completes unchanged.
- Reset mid-fill after idx 6 with a read outstanding → all outputs 0 next cycle, late mem_rvalid ignored; a new spill then runs normally.
- Wrap-around: spill with sp=0xFFFFFFE0 → addresses 0xFFFFFFE0..0xFFFFFFFC, then 0x00000000..0x0000001C; no err.
